// File: rtl/control_stage_seq_pkg.sv
// Shared definitions for the DNN control stage sequencer: stage codes and modes.
package dnn_ctrl_pkg;

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] LOAD_W = 4'd1;
    localparam logic [3:0] LOAD_X = 4'd2;
    localparam logic [3:0] MAC    = 4'd3;
    localparam logic [3:0] ACT    = 4'd4;
    localparam logic [3:0] AD_FWD = 4'd5;
    localparam logic [3:0] AD_BWD = 4'd6;
    localparam logic [3:0] ERR    = 4'd7;
    localparam logic [3:0] GRAD   = 4'd8;
    localparam logic [3:0] WUPD   = 4'd9;
    localparam logic [3:0] DONE   = 4'd10;

    localparam logic MODE_INF = 1'b0;
    localparam logic MODE_TRN = 1'b1;

    // Codes 11..15 are never entered on purpose; they only show up after an upset.
    function automatic logic is_valid_stage(input logic [3:0] stage);
        return stage <= DONE;
    endfunction

endpackage

// File: rtl/control_stage_seq_if.sv
// Host-side handshake and stage status bundle of the stage sequencer.
interface control_stage_seq_if;
    logic       start;
    logic       mode;
    logic       stall;
    logic [3:0] rd_stage;
    logic [3:0] layer_idx;
    logic [7:0] stage_cnt;
    logic       stage_first;
    logic       stage_last;
    logic       busy;
    logic       done;

    modport master (
        output start, mode, stall,
        input  rd_stage, layer_idx, stage_cnt, stage_first, stage_last, busy, done
    );

    modport slave (
        input  start, mode, stall,
        output rd_stage, layer_idx, stage_cnt, stage_first, stage_last, busy, done
    );
endinterface

// File: rtl/control_stage_seq_stage_len_lut.sv
// Stage code to stage length (in cycles) lookup; single-cycle stages and IDLE map to 1.
module stage_len_lut
    import dnn_ctrl_pkg::*;
#(
    parameter int LD_CYC  = 4,
    parameter int MAC_CYC = 16
) (
    input  logic [3:0] stage,
    output logic [7:0] len
);

    // Pure decode, no state.
    always_comb begin
        len = 8'd1;
        case (stage)
            LOAD_W, LOAD_X, ERR, WUPD: len = 8'(LD_CYC);
            MAC, GRAD:                 len = 8'(MAC_CYC);
            default:                   len = 8'd1;
        endcase
    end

endmodule

// File: rtl/control_stage_seq.sv
// Layer-by-layer stage sequencer for the inference/training datapath.
//
//  state  | meaning
//  -------+-----------------------------------------------
//  IDLE   | waiting for start, layer index held at 0
//  LOAD_W | weight fetch for current layer (LD_CYC)
//  LOAD_X | activation fetch for current layer (LD_CYC)
//  MAC    | multiply-accumulate (MAC_CYC)
//  ACT    | activation function (1)
//  AD_FWD | forward activation-derivative capture (1)
//  AD_BWD | backward activation-derivative select (1)
//  ERR    | error propagation (LD_CYC)
//  GRAD   | gradient accumulation (MAC_CYC)
//  WUPD   | weight update (LD_CYC)
//  DONE   | one-cycle completion pulse, then IDLE
module control_stage_seq
    import dnn_ctrl_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int MAC_CYC    = 16,
    parameter int LD_CYC     = 4
) (
    input  logic                clk,
    input  logic                rst,
    control_stage_seq_if.slave  bus
);

    localparam logic [3:0] LAST_LAYER = 4'(NUM_LAYERS - 1);

    logic [3:0] stage_q, stage_d;
    logic [3:0] layer_q, layer_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic [7:0] stage_len;
    logic       at_last;

    stage_len_lut #(
        .LD_CYC  (LD_CYC),
        .MAC_CYC (MAC_CYC)
    ) u_len (
        .stage (stage_q),
        .len   (stage_len)
    );

    // Final cycle of the current stage; never true in IDLE or an unused code.
    always_comb begin
        at_last = (stage_q != IDLE) && is_valid_stage(stage_q) && (cnt_q == stage_len - 8'd1);
    end

    // Next stage, counter, layer and latched mode; everything holds while stalled.
    always_comb begin
        stage_d = stage_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (!bus.stall) begin
            if (!is_valid_stage(stage_q)) begin
                stage_d = IDLE;
                layer_d = 4'd0;
                cnt_d   = 8'd0;
            end else if (stage_q == IDLE) begin
                cnt_d   = 8'd0;
                layer_d = 4'd0;
                if (bus.start) begin
                    stage_d = LOAD_W;
                    mode_d  = bus.mode;
                end
            end else if (!at_last) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = 8'd0;
                case (stage_q)
                    LOAD_W: stage_d = LOAD_X;
                    LOAD_X: stage_d = MAC;
                    MAC:    stage_d = ACT;
                    ACT:    stage_d = AD_FWD;
                    AD_FWD: begin
                        if (layer_q < LAST_LAYER) begin
                            layer_d = layer_q + 4'd1;
                            stage_d = LOAD_W;
                        end else if (mode_q == MODE_TRN) begin
                            stage_d = AD_BWD;
                        end else begin
                            stage_d = DONE;
                        end
                    end
                    AD_BWD: stage_d = ERR;
                    ERR:    stage_d = GRAD;
                    GRAD:   stage_d = WUPD;
                    WUPD: begin
                        if (layer_q != 4'd0) begin
                            layer_d = layer_q - 4'd1;
                            stage_d = AD_BWD;
                        end else begin
                            stage_d = DONE;
                        end
                    end
                    DONE: begin
                        stage_d = IDLE;
                        layer_d = 4'd0;
                    end
                    default: begin
                        stage_d = IDLE;
                        layer_d = 4'd0;
                    end
                endcase
            end
        end
    end

    // State registers; reset wins over stall and start.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= IDLE;
            layer_q <= 4'd0;
            cnt_q   <= 8'd0;
            mode_q  <= MODE_INF;
        end else begin
            stage_q <= stage_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.rd_stage    = stage_q;
        bus.layer_idx   = layer_q;
        bus.stage_cnt   = cnt_q;
        bus.stage_first = (stage_q != IDLE) && (cnt_q == 8'd0);
        bus.stage_last  = at_last;
        bus.busy        = (stage_q != IDLE);
        bus.done        = (stage_q == DONE);
    end

endmodule
